// File: rtl/param_ramp_engine.sv
// Preset-table ramp engine: interpolates NUM_CH channels toward a selected state's presets.
// Define RAMP_SMOOTHSTEP_EN to add the curve_smooth input and a smoothstep ramp shape.
module param_ramp_engine #(
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned WIDTH      = 18,
  parameter int unsigned NUM_STATES = 8,
  parameter int unsigned SW         = 3,
  parameter int unsigned CW         = 4,
  parameter int unsigned DUR_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [SW-1:0]           state_select,
  input  logic [DUR_W-1:0]        transition_duration,
`ifdef RAMP_SMOOTHSTEP_EN
  input  logic                    curve_smooth,
`endif
  input  logic                    cfg_we,
  input  logic [SW-1:0]           cfg_state,
  input  logic [CW-1:0]           cfg_ch,
  input  logic [WIDTH-1:0]        cfg_data,
  output logic [NUM_CH*WIDTH-1:0] out_bus,
  output logic                    frame_valid,
  output logic                    transitioning,
  output logic [15:0]             transition_progress,
  output logic [SW-1:0]           transition_from,
  output logic [SW-1:0]           transition_to,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned SI = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1;
  localparam int unsigned CI = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned MA = (WIDTH + 1 > 18) ? WIDTH + 1 : 18;
  localparam logic [SW:0]   NumStatesW = (SW + 1)'(NUM_STATES);
  localparam logic [CW:0]   NumChW     = (CW + 1)'(NUM_CH);
  localparam logic [CW-1:0] LastCh     = CW'(NUM_CH - 1);

  typedef enum logic [2:0] {StIdle, StDiv, StSmooth, StSweep, StDone} state_e;
  state_e state_q, state_d;

  logic [WIDTH-1:0] preset_q [NUM_STATES][NUM_CH];
  logic [WIDTH-1:0] start_q  [NUM_CH];
  logic [WIDTH-1:0] work_q   [NUM_CH];
  logic [DUR_W-1:0] t_q, dur_q, dur_eff, rem_q;
  logic             snap_q;
  logic [4:0]       div_cnt_q;
  logic [15:0]      quo_q;
  logic [16:0]      p_q, quo_nx;
  logic [CW-1:0]    ch_q;
  logic [DUR_W:0]   rem_sh, rem_nx;
  logic             rem_ge, smooth_on, sm_done, unused_bits;

  logic [WIDTH-1:0]        tgt, st, work_val;
  logic signed [WIDTH:0]   delta;
  logic signed [MA-1:0]    mul_a;
  logic signed [17:0]      mul_b;
  logic signed [MA+17:0]   mul_p;

`ifdef RAMP_SMOOTHSTEP_EN
  logic        smooth_q;
  logic [1:0]  sm_cnt_q;
  logic [16:0] p2_q, p3_q;
  logic [19:0] q_w;
  assign smooth_on = smooth_q;
  assign sm_done   = (sm_cnt_q == 2'd2);
  assign q_w       = 20'(p2_q) + 20'({p2_q, 1'b0}) - 20'({p3_q, 1'b0});
`else
  assign smooth_on = 1'b0;
  assign sm_done   = 1'b1;
`endif

  assign busy    = (state_q != StIdle);
  assign dur_eff = (transition_duration == '0) ? DUR_W'(1) : transition_duration;

  // Restoring divider: first step tests t >= D, then 16 fraction bits of t/D.
  assign rem_sh = (div_cnt_q == 5'd0) ? {1'b0, t_q} : {rem_q, 1'b0};
  assign rem_ge = (rem_sh >= {1'b0, dur_q});
  assign rem_nx = rem_ge ? (rem_sh - {1'b0, dur_q}) : rem_sh;
  assign quo_nx = {quo_q, rem_ge};

  assign tgt = ({1'b0, transition_to} < NumStatesW) ?
               preset_q[transition_to[SI-1:0]][ch_q[CI-1:0]] : '0;
  assign st  = start_q[ch_q[CI-1:0]];
  assign delta = {tgt[WIDTH-1], tgt} - {st[WIDTH-1], st};
  assign mul_b = $signed({1'b0, p_q});
  assign mul_p = mul_a * mul_b;
  // Floor shift by 16 is a plain slice of the two's-complement product.
  assign work_val = st + mul_p[WIDTH+15:16];
  assign unused_bits = ^{mul_p[15:0], mul_p[MA+17:WIDTH+16], rem_nx[DUR_W]};

  always_comb begin
    mul_a = MA'(delta);
`ifdef RAMP_SMOOTHSTEP_EN
    if (state_q == StSmooth) begin
      mul_a = (sm_cnt_q == 2'd0) ? MA'({1'b0, p_q}) : MA'({1'b0, p2_q});
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (clk_en && (state_select == transition_to) && transitioning) state_d = StDiv;
      StDiv:    if (div_cnt_q == 5'd16) state_d = smooth_on ? StSmooth : StSweep;
      StSmooth: if (sm_done) state_d = StSweep;
      StSweep:  if (ch_q == LastCh) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        for (int c = 0; c < NUM_CH; c++) preset_q[s][c] <= '0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        start_q[c] <= '0;
        work_q[c]  <= '0;
      end
      out_bus             <= '0;
      frame_valid         <= 1'b0;
      transitioning       <= 1'b0;
      transition_progress <= '0;
      transition_from     <= '0;
      transition_to       <= '0;
      overrun             <= 1'b0;
      t_q                 <= '0;
      dur_q               <= '0;
      snap_q              <= 1'b0;
      div_cnt_q           <= '0;
      rem_q               <= '0;
      quo_q               <= '0;
      p_q                 <= '0;
      ch_q                <= '0;
    end else begin
      frame_valid <= (state_q == StDone);
      if (clk_en && (state_q != StIdle)) overrun <= 1'b1;
      if (cfg_we && ({1'b0, cfg_state} < NumStatesW) && ({1'b0, cfg_ch} < NumChW)) begin
        preset_q[cfg_state[SI-1:0]][cfg_ch[CI-1:0]] <= cfg_data;
      end
      unique case (state_q)
        StIdle: begin
          if (clk_en) begin
            if (state_select != transition_to) begin
              for (int c = 0; c < NUM_CH; c++) start_q[c] <= out_bus[c*WIDTH +: WIDTH];
              transition_from     <= transition_to;
              transition_to       <= state_select;
              transitioning       <= 1'b1;
              t_q                 <= '0;
              transition_progress <= '0;
            end else if (transitioning) begin
              dur_q     <= dur_eff;
              snap_q    <= (t_q >= dur_eff);
              div_cnt_q <= '0;
            end
          end
        end
        StDiv: begin
          rem_q     <= rem_nx[DUR_W-1:0];
          quo_q     <= quo_nx[15:0];
          div_cnt_q <= div_cnt_q + 5'd1;
          if (div_cnt_q == 5'd16) begin
            p_q  <= snap_q ? 17'h10000 : quo_nx;
            ch_q <= '0;
          end
        end
        StSmooth: begin
`ifdef RAMP_SMOOTHSTEP_EN
          if (sm_done) p_q <= (q_w > 20'h10000) ? 17'h10000 : q_w[16:0];
`endif
        end
        StSweep: begin
          work_q[ch_q[CI-1:0]] <= work_val;
          ch_q                 <= ch_q + 1'b1;
        end
        StDone: begin
          for (int c = 0; c < NUM_CH; c++) out_bus[c*WIDTH +: WIDTH] <= work_q[c];
          if (snap_q) begin
            transitioning       <= 1'b0;
            transition_progress <= 16'hFFFF;
          end else begin
            transition_progress <= p_q[16] ? 16'hFFFF : p_q[15:0];
            t_q                 <= (t_q == '1) ? t_q : t_q + DUR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAMP_SMOOTHSTEP_EN
  // p^2 and p^3 in Q16 on the shared multiplier, then 3p^2 - 2p^3.
  always_ff @(posedge clk) begin
    if (rst) begin
      smooth_q <= 1'b0;
      sm_cnt_q <= '0;
      p2_q     <= '0;
      p3_q     <= '0;
    end else begin
      if ((state_q == StIdle) && clk_en && (state_select != transition_to)) begin
        smooth_q <= curve_smooth;
      end
      if (state_q == StDiv) sm_cnt_q <= '0;
      if (state_q == StSmooth) begin
        sm_cnt_q <= sm_cnt_q + 2'd1;
        if (sm_cnt_q == 2'd0) p2_q <= mul_p[32:16];
        if (sm_cnt_q == 2'd1) p3_q <= mul_p[32:16];
      end
    end
  end
`endif

endmodule

// File: tb/tb_param_ramp_engine.sv
// Directed, table-driven bench for param_ramp_engine with a 4-channel build.
module tb_param_ramp_engine;

  localparam int NCH = 4;
  localparam int W   = 18;
  localparam int SWB = 4;
  localparam int CWB = 2;
  localparam int DW  = 16;
  localparam int LAT = NCH + 19;

  logic              clk = 1'b0;
  logic              rst, clk_en, cfg_we;
  logic [SWB-1:0]    state_select, cfg_state, transition_from, transition_to;
  logic [DW-1:0]     transition_duration;
  logic [CWB-1:0]    cfg_ch;
  logic [W-1:0]      cfg_data;
  logic [NCH*W-1:0]  out_bus;
  logic              frame_valid, transitioning, busy, overrun;
  logic [15:0]       transition_progress;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_ramp_engine #(
    .NUM_CH(NCH), .WIDTH(W), .NUM_STATES(8), .SW(SWB), .CW(CWB), .DUR_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .state_select(state_select),
    .transition_duration(transition_duration), .cfg_we(cfg_we), .cfg_state(cfg_state),
    .cfg_ch(cfg_ch), .cfg_data(cfg_data), .out_bus(out_bus), .frame_valid(frame_valid),
    .transitioning(transitioning), .transition_progress(transition_progress),
    .transition_from(transition_from), .transition_to(transition_to), .busy(busy),
    .overrun(overrun)
  );

  typedef struct {
    int sel; int dur;
    int wr; int wst; int wch; int wdat;
    int frame;
    int o0; int o1; int o2; int o3;
    int prog; int trans; int from; int to;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(int sel, int dur, int wr, int wst, int wch, int wdat, int frame,
                              int o0, int o1, int o2, int o3, int prog, int trans,
                              int from, int to);
    vec_t v;
    v.sel = sel; v.dur = dur; v.wr = wr; v.wst = wst; v.wch = wch; v.wdat = wdat;
    v.frame = frame; v.o0 = o0; v.o1 = o1; v.o2 = o2; v.o3 = o3;
    v.prog = prog; v.trans = trans; v.from = from; v.to = to;
    return v;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [63:0] chv(int c);
    logic signed [W-1:0] x;
    x = out_bus[c*W +: W];
    return 64'(x);
  endfunction

  task automatic wr(input int st, input int ch, input int d);
    cfg_state = SWB'(st);
    cfg_ch    = CWB'(ch);
    cfg_data  = W'(d);
    cfg_we    = 1'b1;
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic write_presets();
    wr(1, 0, 100); wr(1, 1, -100); wr(1, 2, 8192); wr(1, 3, 0);
    for (int c = 0; c < NCH; c++) wr(2, c, 40);
    wr(3, 0, 7); wr(3, 1, -7); wr(3, 2, 1000); wr(3, 3, -131072);
  endtask

  // One tick, then 40 cycles of observation; lat is the cycle offset of the first frame.
  task automatic do_tick(output int lat, output int nfr);
    lat = -1;
    nfr = 0;
    clk_en = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      clk_en = 1'b0;
      if (frame_valid) begin
        nfr++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int lat, nfr;
    for (int i = lo; i <= hi; i++) begin
      vec_t v;
      v = tv[i];
      if (v.wr != 0) wr(v.wst, v.wch, v.wdat);
      state_select        = SWB'(v.sel);
      transition_duration = DW'(v.dur);
      do_tick(lat, nfr);
      chk($sformatf("v%0d.latency", i), lat, (v.frame != 0) ? LAT : -1);
      chk($sformatf("v%0d.frames", i), nfr, (v.frame != 0) ? 1 : 0);
      chk($sformatf("v%0d.ch0", i), chv(0), v.o0);
      chk($sformatf("v%0d.ch1", i), chv(1), v.o1);
      chk($sformatf("v%0d.ch2", i), chv(2), v.o2);
      chk($sformatf("v%0d.ch3", i), chv(3), v.o3);
      chk($sformatf("v%0d.progress", i), transition_progress, v.prog);
      chk($sformatf("v%0d.transitioning", i), transitioning, v.trans);
      chk($sformatf("v%0d.from", i), transition_from, v.from);
      chk($sformatf("v%0d.to", i), transition_to, v.to);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, nfr;
    int fr[$];

    // Linear ramp to state 1 (D = 4), then a repeat select that must do nothing.
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 0,    0,    0,    0, 0,     0, 1, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,    0,    0,    0, 0,     0, 1, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,   25,  -25, 2048, 0, 16384, 1, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,   50,  -50, 4096, 0, 32768, 1, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,   75,  -75, 6144, 0, 49152, 1, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,  100, -100, 8192, 0, 65535, 0, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 0,  100, -100, 8192, 0, 65535, 0, 0, 1));
    // Ramp to 1, retarget to 2 after the t = 2 frame.
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 0,    0,    0,    0, 0,     0, 1, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,    0,    0,    0, 0,     0, 1, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,   25,  -25, 2048, 0, 16384, 1, 0, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,   50,  -50, 4096, 0, 32768, 1, 0, 1));
    tv.push_back(mk(2, 2, 0, 0, 0, 0, 0,   50,  -50, 4096, 0,     0, 1, 1, 2));
    tv.push_back(mk(2, 2, 0, 0, 0, 0, 1,   50,  -50, 4096, 0,     0, 1, 1, 2));
    tv.push_back(mk(2, 2, 0, 0, 0, 0, 1,   45,   -5, 2068, 20, 32768, 1, 1, 2));
    tv.push_back(mk(2, 2, 0, 0, 0, 0, 1,   40,   40,   40, 40, 65535, 0, 1, 2));
    // Instant transition (duration 0) to state 3.
    tv.push_back(mk(3, 0, 0, 0, 0, 0, 0,   40,   40,   40, 40,     0, 1, 2, 3));
    tv.push_back(mk(3, 0, 0, 0, 0, 0, 1,   40,   40,   40, 40,     0, 1, 2, 3));
    tv.push_back(mk(3, 0, 0, 0, 0, 0, 1,    7,   -7, 1000, -131072, 65535, 0, 2, 3));
    // Ramp back to 1 with preset[1][0] rewritten to 200 mid-ramp.
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 0,    7,   -7, 1000, -131072,     0, 1, 3, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,    7,   -7, 1000, -131072,     0, 1, 3, 1));
    tv.push_back(mk(1, 4, 1, 1, 0, 200, 1, 55,  -31, 2798,  -98304, 16384, 1, 3, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,  103,  -54, 4596,  -65536, 32768, 1, 3, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,  151,  -77, 6394,  -32768, 49152, 1, 3, 1));
    tv.push_back(mk(1, 4, 0, 0, 0, 0, 1,  200, -100, 8192,       0, 65535, 0, 3, 1));

    rst = 1'b1; clk_en = 1'b0; cfg_we = 1'b0; cfg_state = '0; cfg_ch = '0; cfg_data = '0;
    state_select = '0; transition_duration = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int c = 0; c < NCH; c++) chk($sformatf("reset.ch%0d", c), chv(c), 0);
    chk("reset.busy", busy, 0);
    chk("reset.transitioning", transitioning, 0);
    chk("reset.overrun", overrun, 0);
    chk("reset.frame_valid", frame_valid, 0);
    chk("reset.progress", transition_progress, 0);

    write_presets();
    wr(9, 2, 555);  // out-of-range state: must not alias onto a real entry
    run_vecs(0, 6);

    // Reset held two cycles in the middle of a sweep.
    state_select = SWB'(2);
    transition_duration = DW'(4);
    do_tick(lat, nfr);
    chk("rstseq.start_latency", lat, -1);
    clk_en = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk); #1;
      clk_en = 1'b0;
    end
    chk("rstseq.busy_mid_sweep", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < NCH; c++) chk($sformatf("rstseq.ch%0d", c), chv(c), 0);
    chk("rstseq.transitioning", transitioning, 0);
    chk("rstseq.busy", busy, 0);
    chk("rstseq.overrun", overrun, 0);
    chk("rstseq.to", transition_to, 0);
    chk("rstseq.from", transition_from, 0);
    nfr = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (frame_valid) nfr++;
    end
    chk("rstseq.no_frame", nfr, 0);
    chk("rstseq.busy_after", busy, 0);

    write_presets();
    run_vecs(7, 23);

    // Ticks every 10 clocks: those landing while busy are dropped.
    state_select = SWB'(2);
    transition_duration = DW'(100);
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(posedge clk); #1;
      if (frame_valid) fr.push_back(cyc);
      if (cyc == 20) chk("overrun.before_drop", overrun, 0);
      if (cyc == 25) chk("overrun.after_drop", overrun, 1);
      clk_en = ((cyc % 10) == 0);
    end
    clk_en = 1'b0;
    chk("overrun.frame_count", fr.size(), 3);
    if (fr.size() >= 3) begin
      chk("overrun.first_frame", fr[0], 33);
      chk("overrun.spacing1", fr[1] - fr[0], 30);
      chk("overrun.spacing2", fr[2] - fr[1], 30);
    end
    repeat (50) @(posedge clk);
    #1 chk("overrun.sticky", overrun, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/param_ramp_engine.md
Name: param_ramp_engine

Overview:
- Parametrised successor to the per-state MU/threshold/SIE lookup-and-ramp controller.
- Holds a runtime-writable preset table of NUM_STATES x NUM_CH signed words.
- On each clk_en tick while a transition is active, it interpolates every channel from captured start values toward the selected state's presets.
- One shared divider and one shared multiplier are time-multiplexed across channels. The output bank is published atomically and feeds oscillator MU, Ca2+ threshold and SIE-timing consumers.

Parameters:
NUM_CH, 16, number of interpolated channels
WIDTH, 18, signed channel word width
NUM_STATES, 8, number of preset states
SW, 3, state index width (2^SW >= NUM_STATES)
CW, 4, channel index width (2^CW >= NUM_CH)
DUR_W, 16, transition duration width in ticks

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clk_en  in  1  update tick (4 kHz strobe)
state_select  in  SW  requested target state
transition_duration  in  DUR_W  ramp length in ticks; 0 = instant
cfg_we  in  1  preset write strobe
cfg_state  in  SW  preset write state index
cfg_ch  in  CW  preset write channel index
cfg_data  in  WIDTH  preset write data (signed)
out_bus  out  NUM_CH*WIDTH  channel values, ch0 at LSBs
frame_valid  out  1  one-cycle pulse when out_bus updates
transitioning  out  1  ramp active
transition_progress  out  16  0..0xFFFF ramp position
transition_from  out  SW  source state
transition_to  out  SW  target state
busy  out  1  engine not in IDLE
overrun  out  1  sticky: a clk_en tick was dropped

Behaviour:
- Reset (synchronous, clk edge with rst=1), applies in every FSM state and aborts any sweep. All presets, out_bus, start bank, t counter, progress, from/to, overrun = 0; transitioning, busy, frame_valid = 0; FSM = IDLE.
- Preset writes:
  - Accepted in any FSM state; visible from the next cycle.
  - A same-cycle sweep read of the same entry returns the old value.
  - A write with cfg_state >= NUM_STATES or cfg_ch >= NUM_CH is ignored.
- FSM IDLE -> DIV -> SWEEP -> DONE -> IDLE. Only a clk_en tick in IDLE starts work.
- Tick in IDLE:
  - If state_select != transition_to, start a new transition (retarget allowed mid-ramp):
    - Copy out_bus into the start bank; transition_from <= transition_to; transition_to <= state_select.
    - transitioning <= 1; t <= 0; progress <= 0.
    - No sweep is run this tick.
  - Else if transitioning, run a sweep: go to DIV.
  - Else: no action, no frame_valid.
- Effective duration D = max(transition_duration, 1), sampled at each tick.
- DIV (17 cycles): restoring divider computes p = floor(t*65536/D), a 17-bit value. If t >= D, p is forced to 65536 (snap).
- SWEEP (NUM_CH cycles): channel c = 0..NUM_CH-1, one per cycle.
  - delta = preset[transition_to][c] - start[c], computed at WIDTH+1 bits signed.
  - work[c] = start[c] + ((delta*p) >>> 16), using an arithmetic (floor) shift.
  - The result lies between start and target, so truncation to WIDTH bits is lossless.
  - With p = 65536 the result equals the target exactly.
- DONE (1 cycle):
  - out_bus <= work bank (all channels at once); frame_valid = 1 in the following cycle.
  - If snapped: transitioning <= 0; progress <= 0xFFFF; t unchanged.
  - Else: progress <= min(p, 65535); t <= t + 1, saturating at 2^DUR_W - 1.
- Latency: tick at cycle T gives frame_valid high at cycle T + NUM_CH + 19.
- A clk_en tick while busy is dropped and sets overrun; overrun clears only on reset. Requires clk_en period >= NUM_CH + 20 clocks.
- A state_select change while busy is not sampled until the next IDLE tick.
- duration = 0: the first sweep outputs the start values (p = 0); the next tick snaps.

Optional Feature:
- Macro RAMP_SMOOTHSTEP_EN.
- When defined, adds input curve_smooth (1 bit, sampled at the transition-start tick and held for the whole ramp). When it is 1, p is replaced in DIV+3 extra cycles by q = (3*p^2 - 2*p^3) in Q16, computed serially on the shared multiplier; q(0) = 0 and q(65536) = 65536. Latency becomes NUM_CH + 22 and the minimum clk_en period grows by 3.
- When not defined: the port is absent, the curve is linear only, latency NUM_CH + 19.

Test Plan:
- Reset defaults: NUM_CH=4. Hold rst 2 cycles mid-SWEEP -> out_bus = 0, transitioning = 0, busy = 0, overrun = 0, FSM idle next cycle.
- Linear ramp: preset[1] = {100, -100, 8192, 0}, D = 4, select 1.
  - Frames at t = 0..3 give ch0 = 0, 25, 50, 75 and ch1 = 0, -25, -50, -75.
  - 5th sweep snaps to exactly {100, -100, 8192, 0} with progress 0xFFFF and transitioning = 0.
- Retarget: switch to state 2 (all presets = 40) after the t = 2 frame of the ramp above.
  - start = {50, -50, 4096, 0}; transition_from = 1, transition_to = 2.
  - With D = 2 the frames are {50, -50, 4096, 0}, {45, -5, 2068, 20}, then a snap to 40s.
- Instant: duration 0, select 3 -> first frame = start values; next tick out_bus = preset[3]; frame_valid pulses exactly NUM_CH + 19 cycles after each tick.
- Overrun: clk_en period 10 clocks -> ticks during busy are dropped, overrun = 1 and stays set, frame spacing unchanged.
- Writes: write cfg_state = 9, cfg_ch = 2 -> no effect. Write preset[to][0] = 200 mid-ramp -> the next frame interpolates toward 200.
